// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared constants for the MULT/DIV/DIVM sequencer.
//   Op encodings as driven by control_unit, FSM state encodings,
//   default operand width and the number of iterations per operation.
package muldiv_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int ITER_COUNT = DEF_WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MUL_RUN = 3'd1;
  localparam logic [2:0] ST_DIV_RUN = 3'd2;
  localparam logic [2:0] ST_DIV_FIX = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_EXC     = 3'd5;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step -- one combinational restoring-division step.
//   rem_in       : partial remainder (always < divisor)
//   divisor      : divisor magnitude
//   dividend_bit : next dividend bit, MSB first
//   rem_out      : new partial remainder
//   q_bit        : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           fits_s;

  // Shift in the next dividend bit and trial-subtract. Because rem_in < divisor,
  // shifted < 2*divisor, so a non-negative difference always has a clear MSB.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    fits_s    = ~diff_s[WIDTH];
    q_bit     = fits_s;
    if (fits_s) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- multicycle MULT/DIV/DIVM sequencer started by control_unit.
//   Shift-add multiply (33 clocks) or restoring divide (34 clocks), one step per
//   clock, producing HI/LO with write strobes and a divide-by-zero exception pulse.
// Ports:
//   clk, reset_in (sync, active low)
//   start, op[1:0], src_a, src_b    : request (sampled only in IDLE)
//   busy, done                      : status
//   hi, lo, hi_w, lo_w              : result and HI/LO write strobes
//   div_zero                        : one-cycle exception pulse
// Build option: MULDIV_UNSIGNED_EN enables MULTU/DIVU; otherwise op[1]=1 is
//   illegal and completes with done only (no writes).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_w,
  output logic             lo_w,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r, done_r, hi_w_r, lo_w_r, div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic [2*WIDTH-1:0] acc_r;      // multiply: {partial product, remaining multiplier}
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   rem_r, quo_r, dvsr_r;
  logic               neg_q_r, neg_rm_r, wr_en_r;
  logic [2*WIDTH-1:0] res_r;

  logic               signed_op_s, illegal_op_s, is_div_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s, mul_signed_s;
  logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic               q_bit_s;

  // Op decode and operand magnitudes for the request presented in IDLE.
  always_comb begin
`ifdef MULDIV_UNSIGNED_EN
    signed_op_s  = ~op[1];
    illegal_op_s = 1'b0;
`else
    signed_op_s  = 1'b1;
    illegal_op_s = op[1];
`endif
    is_div_s = (op == OP_DIV) || (op == OP_DIVU);
    if (signed_op_s && src_a[WIDTH-1]) begin
      mag_a_s = ~src_a + ONE_W;
    end else begin
      mag_a_s = src_a;
    end
    if (signed_op_s && src_b[WIDTH-1]) begin
      mag_b_s = ~src_b + ONE_W;
    end else begin
      mag_b_s = src_b;
    end
  end

  // Shift-add multiply step; the final step's sum is signed on its way to WRITE.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    if (neg_q_r) begin
      mul_signed_s = ~mul_next_s + ONE_2W;
    end else begin
      mul_signed_s = mul_next_s;
    end
  end

  // Divide sign fix-up: quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    if (neg_q_r) begin
      fix_lo_s = ~quo_r + ONE_W;
    end else begin
      fix_lo_s = quo_r;
    end
    if (neg_rm_r) begin
      fix_hi_s = ~rem_r + ONE_W;
    end else begin
      fix_hi_s = rem_r;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_r),
    .divisor      (dvsr_r),
    .dividend_bit (quo_r[WIDTH-1]),
    .rem_out      (rem_nxt_s),
    .q_bit        (q_bit_s)
  );

  // Sequencer FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_w_r     <= 1'b0;
      lo_w_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      acc_r      <= '0;
      mcand_r    <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvsr_r     <= '0;
      neg_q_r    <= 1'b0;
      neg_rm_r   <= 1'b0;
      wr_en_r    <= 1'b0;
      res_r      <= '0;
    end else begin
      done_r     <= 1'b0;
      hi_w_r     <= 1'b0;
      lo_w_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            neg_q_r  <= signed_op_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rm_r <= signed_op_s & src_a[WIDTH-1];
            if (illegal_op_s) begin
              wr_en_r <= 1'b0;
              state_r <= ST_WRITE;
            end else if (!is_div_s) begin
              wr_en_r <= 1'b1;
              mcand_r <= mag_a_s;
              acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
              state_r <= ST_MUL_RUN;
            end else if (src_b == '0) begin
              wr_en_r <= 1'b0;
              state_r <= ST_EXC;
            end else begin
              wr_en_r <= 1'b1;
              quo_r   <= mag_a_s;   // dividend bits shift out as quotient bits shift in
              rem_r   <= '0;
              dvsr_r  <= mag_b_s;
              state_r <= ST_DIV_RUN;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_MUL_RUN: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r + ONE_C;
          if (cnt_r == LAST_CNT) begin
            res_r   <= mul_signed_s;
            state_r <= ST_WRITE;
          end else begin
            state_r <= ST_MUL_RUN;
          end
        end
        ST_DIV_RUN: begin
          rem_r <= rem_nxt_s;
          quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
          cnt_r <= cnt_r + ONE_C;
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_DIV_FIX;
          end else begin
            state_r <= ST_DIV_RUN;
          end
        end
        ST_DIV_FIX: begin
          res_r   <= {fix_hi_s, fix_lo_s};
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          if (wr_en_r) begin
            hi_r   <= res_r[2*WIDTH-1:WIDTH];
            lo_r   <= res_r[WIDTH-1:0];
            hi_w_r <= 1'b1;
            lo_w_r <= 1'b1;
          end else begin
            hi_w_r <= 1'b0;
            lo_w_r <= 1'b0;
          end
          state_r <= ST_IDLE;
        end
        ST_EXC: begin
          div_zero_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign hi_w     = hi_w_r;
  assign lo_w     = lo_w_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer -- table-driven directed bench for muldiv_sequencer,
// plus hand-written sequences for divide-by-zero, ignored restart, reset abort
// and the MULTU / illegal-op option (MULDIV_UNSIGNED_EN).
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, hi_w, lo_w, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer dut (
    .clk(clk), .reset_in(reset_in), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .hi_w(hi_w), .lo_w(lo_w), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from the accepting edge to done or div_zero; -1 if the bound expires.
  task automatic wait_evt(output int lat, output int busy_bad);
    int n;
    n = 0; lat = -1; busy_bad = 0;
    while (lat < 0 && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (done || div_zero) lat = n;
      else if (!busy) busy_bad++;
    end
  endtask

  initial begin
    int lat, bb, cnt;
    logic [31:0] prev_hi, prev_lo;

    vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vecs[1] = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[3] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};
    vecs[4] = '{2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        34};
    vecs[5] = '{2'b01, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[6] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};
    vecs[7] = '{2'b01, 32'd3,         32'd5,         32'd3,         32'd0,         34};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[9] = '{2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 34};

    reset_in = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi_w/lo_w", {30'd0, hi_w, lo_w}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    reset_in = 1'b1;

    // Table-driven operations.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_evt(lat, bb);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].e_lat);
      chk($sformatf("vec%0d busy while running", i), bb, 32'd0);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].e_hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].e_lo);
      chk($sformatf("vec%0d strobes", i), {29'd0, done, hi_w, lo_w}, 32'd7);
      @(posedge clk); #1;
      chk($sformatf("vec%0d one-cycle done", i), {29'd0, done, hi_w, lo_w}, 32'd0);
    end
    prev_hi = vecs[9].e_hi;
    prev_lo = vecs[9].e_lo;

    // Divide by zero: exception pulse only, result registers untouched.
    start_op(2'b01, 32'd5, 32'd0);
    wait_evt(lat, bb);
    chk("dz latency", lat, 32'd1);
    chk("dz div_zero", {31'd0, div_zero}, 32'd1);
    chk("dz no strobes", {29'd0, done, hi_w, lo_w}, 32'd0);
    chk("dz hi kept", hi, prev_hi);
    chk("dz lo kept", lo, prev_lo);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done || hi_w || lo_w || div_zero) cnt++;
    end
    chk("dz quiet after pulse", cnt, 32'd0);

    // Overflow divide with a second start at clock 10 that must be ignored.
    start_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    lat = -1; bb = 0; cnt = 0;
    while (lat < 0 && cnt < 100) begin
      cnt++;
      if (cnt == 10) begin
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done || div_zero) lat = cnt;
      else if (!busy) bb++;
    end
    start = 1'b0;
    chk("restart latency", lat, 32'd34);
    chk("restart busy held", bb, 32'd0);
    chk("restart hi", hi, 32'h0000_0000);
    chk("restart lo", lo, 32'h8000_0000);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy || done) cnt++;
    end
    chk("restart not queued", cnt, 32'd0);

    // Reset during a multiply aborts it and clears the results.
    start_op(2'b00, 32'd5, 32'd6);
    repeat (13) @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {29'd0, done, hi_w, lo_w}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    reset_in = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || hi_w || lo_w) cnt++;
    end
    chk("abort no done", cnt, 32'd0);
    start_op(2'b00, 32'd3, 32'd4);
    wait_evt(lat, bb);
    chk("post-reset latency", lat, 32'd33);
    chk("post-reset hi", hi, 32'd0);
    chk("post-reset lo", lo, 32'd12);
    prev_hi = 32'd0;
    prev_lo = 32'd12;
    @(posedge clk); #1;

    // MULTU 0xFFFFFFFF * 2.
    start_op(2'b10, 32'hFFFF_FFFF, 32'd2);
    wait_evt(lat, bb);
`ifdef MULDIV_UNSIGNED_EN
    chk("multu latency", lat, 32'd33);
    chk("multu strobes", {29'd0, done, hi_w, lo_w}, 32'd7);
    chk("multu hi", hi, 32'd1);
    chk("multu lo", lo, 32'hFFFF_FFFE);
`else
    chk("illegal latency", lat, 32'd1);
    chk("illegal strobes", {29'd0, done, hi_w, lo_w}, 32'd4);
    chk("illegal hi kept", hi, prev_hi);
    chk("illegal lo kept", lo, prev_lo);
`endif
    @(posedge clk); #1;
    chk("final done low", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
